// File: rtl/peak_finder.sv
// Pulse peak detector for a signed filter stream. It tracks the maximum and its
// timestamp above threshold, applies a holdoff, and holds results in a one-deep register.
module peak_finder #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SIZE_TIME        = 16,
  parameter int HOLDOFF          = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] input_data,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  input  logic                        peak_ready,
  output logic                        peak_valid,
  output logic [SIZE_FILTER_DATA-1:0] peak_amp,
  output logic [SIZE_TIME-1:0]        peak_time,
  output logic [7:0]                  peak_width,
  output logic [7:0]                  lost_count
);

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  state_t                      state_q, state_d;
  logic [SIZE_TIME-1:0]        ts_q, ts_d;
  logic [7:0]                  hold_q, hold_d;
  logic [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic [SIZE_TIME-1:0]        max_time_q, max_time_d;
  logic [7:0]                  width_q, width_d;
  logic                        valid_q, valid_d;
  logic [SIZE_FILTER_DATA-1:0] amp_q, amp_d;
  logic [SIZE_TIME-1:0]        time_q, time_d;
  logic [7:0]                  pwidth_q, pwidth_d;
  logic [7:0]                  lost_q, lost_d;
  logic                        above;
  logic                        emit;

  assign above = $signed(input_data) > $signed(threshold);

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + 1'b1;
    hold_d     = hold_q;
    max_d      = max_q;
    max_time_d = max_time_q;
    width_d    = width_q;
    emit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (above) begin
          state_d    = ARMED;
          max_d      = input_data;
          max_time_d = ts_q;
          width_d    = 8'd1;
        end
      end
      ARMED: begin
        if (above) begin
          if (width_q != 8'hFF) width_d = width_q + 8'd1;
          // Strict compare: a plateau keeps the timestamp of its first sample.
          if ($signed(input_data) > $signed(max_q)) begin
            max_d      = input_data;
            max_time_d = ts_q;
          end
        end else begin
          emit    = 1'b1;
          state_d = HOLD;
          hold_d  = 8'(HOLDOFF);
        end
      end
      HOLD: begin
        hold_d = hold_q - 8'd1;
        if (hold_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    amp_d    = amp_q;
    time_d   = time_q;
    pwidth_d = pwidth_q;
    lost_d   = lost_q;

    if (emit) begin
      if (!valid_q || peak_ready) begin
        valid_d  = 1'b1;
        amp_d    = max_q;
        time_d   = max_time_q;
        pwidth_d = width_q;
      end else if (lost_q != 8'hFF) begin
        lost_d = lost_q + 8'd1;
      end
    end else if (valid_q && peak_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      hold_q     <= '0;
      max_q      <= '0;
      max_time_q <= '0;
      width_q    <= '0;
      valid_q    <= 1'b0;
      amp_q      <= '0;
      time_q     <= '0;
      pwidth_q   <= '0;
      lost_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      hold_q     <= hold_d;
      max_q      <= max_d;
      max_time_q <= max_time_d;
      width_q    <= width_d;
      valid_q    <= valid_d;
      amp_q      <= amp_d;
      time_q     <= time_d;
      pwidth_q   <= pwidth_d;
      lost_q     <= lost_d;
    end
  end

  assign peak_valid = valid_q;
  assign peak_amp   = amp_q;
  assign peak_time  = time_q;
  assign peak_width = pwidth_q;
  assign lost_count = lost_q;

endmodule

// File: tb/tb_peak_finder.sv
// Directed bench for peak_finder: hand-computed pulses covering emit, backpressure,
// holdoff, ties, negative threshold, saturation, timestamp wrap and reset.
module tb_peak_finder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] input_data = '0;
  logic [15:0] threshold = 16'd10;
  logic        peak_ready = 1'b0;
  logic        peak_valid;
  logic [15:0] peak_amp;
  logic [15:0] peak_time;
  logic [7:0]  peak_width;
  logic [7:0]  lost_count;

  int          checks = 0;
  int          fails = 0;
  logic [15:0] t = '0;  // timestamp the next sample will carry

  peak_finder #(.SIZE_FILTER_DATA(16), .SIZE_TIME(16), .HOLDOFF(4)) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .peak_ready(peak_ready), .peak_valid(peak_valid), .peak_amp(peak_amp),
    .peak_time(peak_time), .peak_width(peak_width), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [15:0] d);
    input_data = d;
    @(posedge clk);
    #1;
    t = t + 16'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    peak_ready = 1'b0;
    step(16'd0);
    step(16'd0);
    reset = 1'b0;
    t = '0;
  endtask

  task automatic test_reset();
    input_data = 16'd77;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", peak_valid); end
    checks++; if (peak_amp !== 16'd0) begin fails++; $display("FAIL reset_amp: got %0d expected 0", peak_amp); end
    checks++; if (peak_time !== 16'd0) begin fails++; $display("FAIL reset_time: got %0d expected 0", peak_time); end
    checks++; if (peak_width !== 8'd0) begin fails++; $display("FAIL reset_width: got %0d expected 0", peak_width); end
    checks++; if (lost_count !== 8'd0) begin fails++; $display("FAIL reset_lost: got %0d expected 0", lost_count); end
    $display("test_reset: outputs after reset valid=%0b amp=%0d", peak_valid, peak_amp);
  endtask

  task automatic test_single_pulse();
    do_reset();
    threshold = 16'd10;
    while (t != 16'd100) step(16'd0);
    step(16'd0); step(16'd20); step(16'd50); step(16'd30);
    checks++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %0b expected 0", peak_valid); end
    step(16'd5);
    checks++; if (peak_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b expected 1", peak_valid); end
    checks++; if (peak_amp !== 16'd50) begin fails++; $display("FAIL single_amp: got %0d expected 50", peak_amp); end
    checks++; if (peak_time !== 16'd102) begin fails++; $display("FAIL single_time: got %0d expected 102", peak_time); end
    checks++; if (peak_width !== 8'd3) begin fails++; $display("FAIL single_width: got %0d expected 3", peak_width); end
    $display("test_single_pulse: amp=%0d time=%0d width=%0d", peak_amp, peak_time, peak_width);
    peak_ready = 1'b1; step(16'd0); peak_ready = 1'b0;
    checks++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL single_consume: got %0b expected 0", peak_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    threshold = 16'd10;
    step(16'd30); step(16'd60); step(16'd0);
    repeat (6) step(16'd0);
    step(16'd70); step(16'd0);
    checks++; if (peak_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %0b expected 1", peak_valid); end
    checks++; if (peak_amp !== 16'd60) begin fails++; $display("FAIL bp_amp: got %0d expected 60", peak_amp); end
    checks++; if (peak_time !== 16'd1) begin fails++; $display("FAIL bp_time: got %0d expected 1", peak_time); end
    checks++; if (peak_width !== 8'd2) begin fails++; $display("FAIL bp_width: got %0d expected 2", peak_width); end
    checks++; if (lost_count !== 8'd1) begin fails++; $display("FAIL bp_lost: got %0d expected 1", lost_count); end
    peak_ready = 1'b1; step(16'd0); peak_ready = 1'b0;
    checks++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL bp_consume: got %0b expected 0", peak_valid); end
    checks++; if (lost_count !== 8'd1) begin fails++; $display("FAIL bp_lost_hold: got %0d expected 1", lost_count); end
    $display("test_backpressure: held amp=%0d lost=%0d", peak_amp, lost_count);
  endtask

  task automatic test_back_to_back();
    do_reset();
    threshold = 16'd10;
    step(16'd25); step(16'd0);
    repeat (6) step(16'd0);
    step(16'd35);
    peak_ready = 1'b1; step(16'd0); peak_ready = 1'b0;
    checks++; if (peak_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %0b expected 1", peak_valid); end
    checks++; if (peak_amp !== 16'd35) begin fails++; $display("FAIL b2b_amp: got %0d expected 35", peak_amp); end
    checks++; if (peak_time !== 16'd8) begin fails++; $display("FAIL b2b_time: got %0d expected 8", peak_time); end
    checks++; if (lost_count !== 8'd0) begin fails++; $display("FAIL b2b_lost: got %0d expected 0", lost_count); end
    $display("test_back_to_back: amp=%0d time=%0d lost=%0d", peak_amp, peak_time, lost_count);
  endtask

  task automatic test_holdoff_ties();
    do_reset();
    threshold = 16'd10;
    step(16'd0); step(16'd40); step(16'd40); step(16'd0);
    checks++; if (peak_time !== 16'd1) begin fails++; $display("FAIL tie_time: got %0d expected 1", peak_time); end
    checks++; if (peak_amp !== 16'd40) begin fails++; $display("FAIL tie_amp: got %0d expected 40", peak_amp); end
    // Four samples land in HOLD and must not start a pulse; the fifth is evaluated in IDLE.
    repeat (4) step(16'd99);
    step(16'd0);
    checks++; if (lost_count !== 8'd0) begin fails++; $display("FAIL holdoff_lost: got %0d expected 0", lost_count); end
    checks++; if (peak_amp !== 16'd40) begin fails++; $display("FAIL holdoff_amp: got %0d expected 40", peak_amp); end
    peak_ready = 1'b1; step(16'd0); peak_ready = 1'b0;
    step(16'd30); step(16'd40);
    threshold = 16'd50;
    step(16'd45);
    threshold = 16'd10;
    checks++; if (peak_amp !== 16'd40 || peak_width !== 8'd2 || peak_valid !== 1'b1) begin
      fails++; $display("FAIL thr_change: got amp=%0d width=%0d valid=%0b expected 40 2 1", peak_amp, peak_width, peak_valid); end
    $display("test_holdoff_ties: tie time=1 threshold-change amp=%0d width=%0d", peak_amp, peak_width);
    do_reset();
    threshold = -16'sd5;
    step(-16'sd20); step(-16'sd3); step(-16'sd1); step(-16'sd10);
    checks++; if ($signed(peak_amp) !== -16'sd1) begin fails++; $display("FAIL neg_amp: got %0d expected -1", $signed(peak_amp)); end
    checks++; if (peak_time !== 16'd2 || peak_width !== 8'd2) begin
      fails++; $display("FAIL neg_time_width: got time=%0d width=%0d expected 2 2", peak_time, peak_width); end
    $display("test_negative_threshold: amp=%0d", $signed(peak_amp));
    threshold = 16'd10;
  endtask

  task automatic test_saturation_wrap();
    do_reset();
    threshold = 16'd10;
    step(16'd0);
    for (int i = 0; i < 300; i++) step((i == 7) ? 16'd50 : 16'd20);
    step(16'd0);
    checks++; if (peak_width !== 8'd255) begin fails++; $display("FAIL sat_width: got %0d expected 255", peak_width); end
    checks++; if (peak_amp !== 16'd50 || peak_time !== 16'd8) begin
      fails++; $display("FAIL sat_peak: got amp=%0d time=%0d expected 50 8", peak_amp, peak_time); end
    $display("test_saturation: width=%0d", peak_width);
    do_reset();
    while (t != 16'hFFFE) step(16'd0);
    step(16'd15); step(16'd25); step(16'd30); step(16'd40); step(16'd5);
    checks++; if (peak_time !== 16'd1) begin fails++; $display("FAIL wrap_time: got %0d expected 1", peak_time); end
    checks++; if (peak_amp !== 16'd40 || peak_width !== 8'd4) begin
      fails++; $display("FAIL wrap_peak: got amp=%0d width=%0d expected 40 4", peak_amp, peak_width); end
    $display("test_wrap: time=%0d amp=%0d", peak_time, peak_amp);
    repeat (5) step(16'd0);
    step(16'd50); step(16'd60);
    reset = 1'b1; step(16'd60); reset = 1'b0; t = '0;
    repeat (3) step(16'd0);
    checks++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL rst_armed_valid: got %0b expected 0", peak_valid); end
    checks++; if (peak_amp !== 16'd0 || peak_time !== 16'd0 || peak_width !== 8'd0) begin
      fails++; $display("FAIL rst_armed_fields: got amp=%0d time=%0d width=%0d expected 0 0 0", peak_amp, peak_time, peak_width); end
    checks++; if (lost_count !== 8'd0) begin fails++; $display("FAIL rst_armed_lost: got %0d expected 0", lost_count); end
    $display("test_reset_armed: valid=%0b lost=%0d", peak_valid, lost_count);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_backpressure();
    test_back_to_back();
    test_holdoff_ties();
    test_saturation_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
